// File: rtl/addsub_rr_arbiter_if.sv
// Request/response bundle between the client blocks and the shared add/sub arbiter.
// The arbiter takes the slave modport and a client-side driver takes master.
interface addsub_rr_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 4,
    parameter int RWIDTH = 8,
    parameter int IDW    = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_op;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [RWIDTH-1:0]     resp_data;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath among NREQ requesters;
// accept in IDLE, compute in EXEC, hold the response in RESP until taken.
module addsub_rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 4,
    parameter int RWIDTH = 8,
    parameter int IDW    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    addsub_rr_arbiter_if.slave bus,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    gnt_q, gnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              op_q, op_d;
    logic [RWIDTH-1:0] resp_data_q, resp_data_d;
    logic [IDW-1:0]    resp_id_q, resp_id_d;

    logic              found;
    logic [IDW-1:0]    win_idx;
    logic [IDW-1:0]    cand;

    function automatic logic [RWIDTH-1:0] addsub(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic             op);
        logic [RWIDTH-1:0] ax;
        logic [RWIDTH-1:0] bx;
        ax = RWIDTH'(a);
        bx = RWIDTH'(b);
        return op ? (ax - bx) : (ax + bx);
    endfunction

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Gated by rst_n so no requester sees an accept while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state_q == IDLE && found) begin
            bus.req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    a_d     = bus.req_a[win_idx*WIDTH +: WIDTH];
                    b_d     = bus.req_b[win_idx*WIDTH +: WIDTH];
                    op_d    = bus.req_op[win_idx];
                    gnt_d   = win_idx;
                    ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resp_data_d = addsub(a_q, b_q, op_q);
                resp_id_d   = gnt_q;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
        end
    end

    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign busy           = (state_q != IDLE);

endmodule
